// File: rtl/fp_unpack_pkg.sv
// rtl/fp_unpack_pkg.sv - shared IEEE-754 unpack types and default format widths
package fp_unpack_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int LZ_N_DEF  = 2**$clog2(MAN_W_DEF+1);
  localparam int LZ_W_DEF  = $clog2(LZ_N_DEF) + 1;

  function automatic int bias_of(input int exp_w);
    return 2**(exp_w-1) - 1;
  endfunction

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  typedef struct packed {
    logic                        sign;
    logic signed [EXP_W_DEF+1:0] exp;
    logic [MAN_W_DEF:0]          sig;
    logic [LZ_W_DEF-1:0]         lz;
    fp_class_t                   cls;
  } fp_unpacked_t;

endpackage

// File: rtl/leadingzero.sv
// rtl/leadingzero.sv - leading-zero counter, returns N for an all-zero input
module leadingzero #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_data,
  output logic [$clog2(N):0]   o_cnt
);

  localparam int CW = $clog2(N) + 1;

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (i_data[i]) o_cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_norm.sv
// rtl/fp_unpack_norm.sv - two-stage elastic IEEE-754 operand unpacker and normalizer
module fp_unpack_norm
  import fp_unpack_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = bias_of(EXP_W)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXP_W+MAN_W:0]                   in_op,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_sign,
  output logic signed [EXP_W+1:0]                out_exp,
  output logic [MAN_W:0]                         out_sig,
  output logic [$clog2(2**$clog2(MAN_W+1)):0]    out_lz,
  output logic                                   out_zero,
  output logic                                   out_sub,
  output logic                                   out_inf,
  output logic                                   out_nan,
  output logic                                   out_snan
);

  localparam int LZ_N = 2**$clog2(MAN_W+1);
  localparam int LZ_W = $clog2(LZ_N) + 1;
  localparam int XW   = EXP_W + 2;
  localparam int PAD  = LZ_N - MAN_W - 1;

  logic               w_in_sign;
  logic [EXP_W-1:0]   w_in_e;
  logic [MAN_W-1:0]   w_in_frac;
  logic               w_s2_adv;
  logic               w_s1_adv;

  logic               r1_valid;
  logic               r1_sign;
  logic [EXP_W-1:0]   r1_e;
  logic [MAN_W-1:0]   r1_frac;
  logic               r1_zero;
  logic               r1_sub;
  logic               r1_special;

  logic [MAN_W:0]     w_s;
  logic [LZ_N-1:0]    w_lz_in;
  logic [LZ_W-1:0]    w_lz;
  logic signed [XW-1:0] w_e_eff;
  logic signed [XW-1:0] w_exp;
  logic [MAN_W:0]     w_sig;
  logic [LZ_W-1:0]    w_lz_o;
  fp_class_t          w_cls;

  logic               r2_valid;
  logic               r2_sign;
  logic signed [XW-1:0] r2_exp;
  logic [MAN_W:0]     r2_sig;
  logic [LZ_W-1:0]    r2_lz;
  fp_class_t          r2_cls;

  assign w_in_sign = in_op[EXP_W+MAN_W];
  assign w_in_e    = in_op[MAN_W +: EXP_W];
  assign w_in_frac = in_op[MAN_W-1:0];

  // Stage 1 may refill in the same cycle stage 2 drains it.
  assign w_s2_adv = !r2_valid || out_ready;
  assign w_s1_adv = !r1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_e       <= '0;
      r1_frac    <= '0;
      r1_zero    <= 1'b0;
      r1_sub     <= 1'b0;
      r1_special <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign    <= w_in_sign;
        r1_e       <= w_in_e;
        r1_frac    <= w_in_frac;
        r1_zero    <= (w_in_e == '0) && (w_in_frac == '0);
        r1_sub     <= (w_in_e == '0) && (w_in_frac != '0);
        r1_special <= &w_in_e;
      end
    end
  end

  assign w_s     = {r1_e != '0, r1_frac};
  assign w_lz_in = LZ_N'(w_s) << PAD;

  leadingzero #(
    .N(LZ_N)
  ) u_lz (
    .i_data (w_lz_in),
    .o_cnt  (w_lz)
  );

  // Subnormals use the minimum normal exponent before shifting.
  assign w_e_eff = (r1_e == '0) ? XW'(1) : XW'(r1_e);

  always_comb begin
    w_sig     = w_s << w_lz;
    w_exp     = w_e_eff - XW'(BIAS) - XW'(w_lz);
    w_lz_o    = w_lz;
    w_cls     = '0;
    w_cls.sub = r1_sub;
    if (r1_zero) begin
      w_sig      = '0;
      w_exp      = '0;
      w_lz_o     = '0;
      w_cls.zero = 1'b1;
    end else if (r1_special) begin
      w_sig      = {1'b1, r1_frac};
      w_exp      = XW'(2**EXP_W - 1 - BIAS);
      w_lz_o     = '0;
      w_cls.inf  = (r1_frac == '0);
      w_cls.nan  = (r1_frac != '0);
      w_cls.snan = (r1_frac != '0) && !r1_frac[MAN_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_sig   <= '0;
      r2_lz    <= '0;
      r2_cls   <= '0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign;
        r2_exp  <= w_exp;
        r2_sig  <= w_sig;
        r2_lz   <= w_lz_o;
        r2_cls  <= w_cls;
      end
    end
  end

  assign out_valid = r2_valid;
  assign out_sign  = r2_sign;
  assign out_exp   = r2_exp;
  assign out_sig   = r2_sig;
  assign out_lz    = r2_lz;
  assign out_zero  = r2_cls.zero;
  assign out_sub   = r2_cls.sub;
  assign out_inf   = r2_cls.inf;
  assign out_nan   = r2_cls.nan;
  assign out_snan  = r2_cls.snan;

endmodule

// File: doc/fp_unpack_norm.md
Name: fp_unpack_norm

Overview:
Pipelined IEEE-754 operand unpacker that sits directly upstream of the FPU datapath.
- Splits a packed operand into sign, unbiased signed exponent and explicit-hidden-bit significand.
- Classifies the operand (zero, subnormal, inf, qNaN, sNaN).
- Normalizes subnormals, using the `leadingzero` count to left-shift the significand and adjust the exponent.
- Two-stage elastic pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width (hidden bit excluded)
- BIAS, 2**(EXP_W-1)-1, exponent bias
- LZ_N (derived, localparam), 2**$clog2(MAN_W+1), width fed to leadingzero

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  unpacker can accept this cycle
- in_op  in  1+EXP_W+MAN_W  packed operand {sign, exp, frac}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts this cycle
- out_sign  out  1  sign bit
- out_exp  out  EXP_W+2  signed unbiased exponent
- out_sig  out  MAN_W+1  normalized significand, MSB = hidden bit
- out_lz  out  $clog2(LZ_N)+1  normalization shift applied
- out_zero, out_sub, out_inf, out_nan, out_snan  out  1 each  class flags

Behaviour:
- Reset: synchronous active-high on clk. out_valid=0; all out_* data and flag registers = 0; internal stage-1 valid = 0. in_ready=1 in the first cycle after reset deasserts. A reset asserted mid-operation discards both stages; no partial result emerges.
- Stage 1 (register on accept, in_valid && in_ready):
  - Latch sign, E, frac.
  - s = {E!=0, frac}.
  - Class bits: zero (E==0, frac==0), sub (E==0, frac!=0), special (E all ones).
- Stage 1 → stage 2 (combinational between the registers):
  - `leadingzero` instance, n=LZ_N, on {s, (LZ_N-MAN_W-1) zeros}.
  - Count lz is valid 0..LZ_N; lz==LZ_N only for zero.
- Stage 2 (output register):
  - Normal or sub: out_sig = s << lz; out_exp = (E==0 ? 1 : E) - BIAS - lz, computed in EXP_W+2-bit signed arithmetic.
  - Zero: out_sig=0, out_exp=0, out_lz=0, out_zero=1.
  - Inf/NaN: out_sig = {1, frac}, out_exp = 2**EXP_W-1-BIAS, lz=0.
    - out_inf = (frac==0).
    - out_nan = (frac!=0).
    - out_snan = out_nan && frac[MAN_W-1]==0.
  - out_sub is set only for subnormal inputs. Flags are one-hot except snan, which implies nan.
- Handshake:
  - Latency 2 cycles from accept to out_valid with no backpressure; throughput 1/cycle.
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances when stage 2 advances or stage 1 is empty.
  - in_ready = !s1_valid || stage-2 advance. This is a combinational path from out_ready (permitted).
  - Outputs stay stable while out_valid && !out_ready.
  - Simultaneous drain and fill of a stage in one cycle is required; no bubble.
  - Ordering strictly FIFO; no drop, no duplication.
- Width rule: out_exp range for single precision is -149..+128, which fits 10-bit signed.

Decomposition:
- Package fp_unpack_pkg:
  - EXP_W/MAN_W/BIAS defaults.
  - fp_class_t struct {zero, sub, inf, nan, snan}.
  - Packed unpacked-operand struct {sign, exp, sig, lz, class}, reused by downstream stages.
- Single sub-module: existing `leadingzero`, instantiated once between stages. No other hierarchy.

Test Plan (single precision):
- 0x3F800000 → out_exp=0, out_sig=0x800000, lz=0, no flags, out_valid 2 cycles after accept.
- 0x00000001 → out_sub=1, lz=23, out_exp=-149, out_sig=0x800000.
- 0x00400000 → out_sub=1, lz=1, out_exp=-127, out_sig=0x800000.
- 0x80000000 → out_zero=1, out_sign=1, sig=0, exp=0.
- 0x7F800000 → out_inf=1.
- 0x7F800001 → out_nan=1, out_snan=1.
- 0x7FC00000 → out_nan=1, out_snan=0.
- Backpressure: stream 0x3F800000, 0x40000000, 0x00000001 back to back with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - Outputs hold stable.
  - On release, results emerge in order with exp 0, 1, -149, one per cycle.
- Reset mid-stream: assert rst with both stages full → next cycle out_valid=0, all outputs 0, in_ready=1; the stale operand never appears.
